// File: rtl/uart_rx_async.sv
// uart_rx_async: 16x-oversampled UART receiver feeding a holding register or an external RX FIFO.
module uart_rx_async #(
    parameter int RX_FIFO = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic [7:0] rx_dout,
    output logic       rxrdy,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow,
    output logic       fifo_write_rx
);
    localparam bit FIFO = (RX_FIFO != 0);

    typedef enum logic [2:0] {rx_idle, rx_start, rx_data, rx_parity, rx_stop, rx_break} state_t;

    state_t     state_q, state_d;
    logic       rx_m_q, rx_s_q;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_q, perr_d;
    logic [7:0] dout_q, dout_d;
    logic       rdy_q, rdy_d, pe_q, pe_d, fe_q, fe_d, ov_q, ov_d, wr_q, wr_d;
    logic       mid, smp, done;

    assign mid = baud_clock && cnt_q == 4'd7;
    assign smp = baud_clock && cnt_q == 4'd15;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        done    = 1'b0;
        case (state_q)
            rx_idle: if (baud_clock && !rx_s_q) begin
                state_d = rx_start;
                bit_d   = 3'd0;
                shift_d = 8'h00;
                perr_d  = 1'b0;
            end
            rx_start: if (mid) state_d = rx_s_q ? rx_idle : rx_data;
            rx_data: if (smp) begin
                shift_d[bit_q] = rx_s_q;
                bit_d = bit_q + 3'd1;
                if (bit_q == (bit8 ? 3'd7 : 3'd6)) begin
                    bit_d   = 3'd0;
                    state_d = parity_en ? rx_parity : rx_stop;
                end
            end
            rx_parity: if (smp) begin
                perr_d  = rx_s_q ^ odd_n_even ^ (^shift_q);
                state_d = rx_stop;
            end
            rx_stop: if (smp) begin
                done    = 1'b1;
                state_d = rx_s_q ? rx_idle : rx_break;
            end
            rx_break: if (rx_s_q) state_d = rx_idle;
            default: state_d = rx_idle;
        endcase
        cnt_d = (state_d != state_q) ? 4'd0 : cnt_q + {3'b000, baud_clock};
    end

    // A read and a completion in the same clk: the clear applies first, then the new byte's flags.
    always_comb begin
        dout_d = done ? shift_q : dout_q;
        pe_d   = (pe_q & ~read_rx_byte) | (done & parity_en & perr_q);
        fe_d   = (fe_q & ~read_rx_byte) | (done & ~rx_s_q);
        ov_d   = (ov_q & ~read_rx_byte) | (done & (FIFO ? fifo_full : rdy_q & ~read_rx_byte));
        rdy_d  = FIFO ? 1'b0 : done | (rdy_q & ~read_rx_byte);
        wr_d   = ~(FIFO & done & ~fifo_full);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= rx_idle;
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            cnt_q   <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            perr_q  <= 1'b0;
            dout_q  <= 8'h00;
            rdy_q   <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            wr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            rx_m_q  <= rx;
            rx_s_q  <= rx_m_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            wr_q    <= wr_d;
        end
    end

    assign rx_dout       = dout_q;
    assign rxrdy         = FIFO ? ~fifo_empty : rdy_q;
    assign parity_err    = pe_q;
    assign framing_err   = fe_q;
    assign overflow      = ov_q;
    assign fifo_write_rx = wr_q;
endmodule

// File: tb/tb_uart_rx_async.sv
// tb_uart_rx_async: holding-register and FIFO variants driven by the same serial line.
module tb_uart_rx_async;
    logic clk = 1'b0, reset_n = 1'b0, baud_clock = 1'b0, rx = 1'b1;
    logic bit8 = 1'b1, parity_en = 1'b0, odd_n_even = 1'b0, read_rx_byte = 1'b0;
    logic fifo_full = 1'b0, fifo_empty = 1'b1;
    logic [7:0] dout0, dout1;
    logic rdy0, rdy1, pe0, pe1, fe0, fe1, ov0, ov1, wr0, wr1;
    logic [1:0] bdiv = 2'd0;
    int cyc = 0, wr_cyc = -1, frame_t0 = 0, lat = 613;
    int checks = 0, errors = 0;
    logic [7:0] sb[$];
    logic wr1_prev = 1'b1;

    typedef struct {
        logic [7:0] d;
        logic b8, pen, odd, flip;
        logic [7:0] exp_d;
        logic exp_pe;
    } vec_t;
    vec_t v[9];

    uart_rx_async #(.RX_FIFO(0)) u0 (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
        .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .rx_dout(dout0), .rxrdy(rdy0),
        .parity_err(pe0), .framing_err(fe0), .overflow(ov0), .fifo_write_rx(wr0)
    );
    uart_rx_async #(.RX_FIFO(1)) u1 (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
        .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .rx_dout(dout1), .rxrdy(rdy1),
        .parity_err(pe1), .framing_err(fe1), .overflow(ov1), .fifo_write_rx(wr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bdiv       <= bdiv + 2'd1;
        baud_clock <= (bdiv == 2'd3);
        cyc        <= cyc + 1;
    end

    // FIFO-side scoreboard: every low write strobe must match the oldest expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!wr1) begin
            checks++;
            wr_cyc = cyc;
            if (!wr1_prev) begin
                errors++;
                $display("FAIL fifo_wr_width strobe low for more than one clk");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL fifo_wr_unexpected actual %h required no write", dout1);
            end else begin
                e = sb.pop_front();
                if (dout1 !== e) begin
                    errors++;
                    $display("FAIL fifo_wr_data actual %h required %h", dout1, e);
                end
            end
        end
        wr1_prev = wr1;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %b required %b", name, act, exp);
        end
    endtask

    task automatic align();
        do @(negedge clk); while (bdiv != 2'd0);
    endtask

    task automatic send(input logic [7:0] d, input logic flip);
        logic p;
        p = ^(bit8 ? d : {1'b0, d[6:0]}) ^ odd_n_even ^ flip;
        frame_t0 = cyc;
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < (bit8 ? 8 : 7); i++) begin
            rx = d[i];
            repeat (64) @(negedge clk);
        end
        if (parity_en) begin
            rx = p;
            repeat (64) @(negedge clk);
        end
        rx = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] d, input logic flip);
        align();
        send(d, flip);
    endtask

    task automatic rd();
        read_rx_byte = 1'b1;
        @(negedge clk);
        read_rx_byte = 1'b0;
    endtask

    initial begin
        v[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0};
        v[1] = '{8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA3, 1'b0};
        v[2] = '{8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b1};
        v[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
        v[4] = '{8'h2B, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2B, 1'b1};
        v[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0};
        v[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        v[7] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1};
        v[8] = '{8'hD6, 1'b0, 1'b1, 1'b1, 1'b0, 8'h56, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_dout", dout0, 8'h00);
        chkb("rst_rxrdy", rdy0, 1'b0);
        chkb("rst_perr", pe0, 1'b0);
        chkb("rst_ferr", fe0, 1'b0);
        chkb("rst_ovf", ov0, 1'b0);
        chkb("rst_wr0", wr0, 1'b1);
        chkb("rst_wr1", wr1, 1'b1);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            bit8 = v[i].b8;
            parity_en = v[i].pen;
            odd_n_even = v[i].odd;
            sb.push_back(v[i].exp_d);
            frame(v[i].d, v[i].flip);
            repeat (128) @(negedge clk);
            if (i == 0) begin
                checks++;
                if (wr_cyc - frame_t0 < 600 || wr_cyc - frame_t0 > 625) begin
                    errors++;
                    $display("FAIL latency actual %0d required 600..625", wr_cyc - frame_t0);
                end else lat = wr_cyc - frame_t0;
            end
            chk($sformatf("v%0d_dout", i), dout0, v[i].exp_d);
            chkb($sformatf("v%0d_rxrdy", i), rdy0, 1'b1);
            chkb($sformatf("v%0d_perr", i), pe0, v[i].exp_pe);
            chkb($sformatf("v%0d_perr_fifo", i), pe1, v[i].exp_pe);
            chkb($sformatf("v%0d_ferr", i), fe0, 1'b0);
            chkb($sformatf("v%0d_ovf", i), ov0, 1'b0);
            rd();
            chkb($sformatf("v%0d_rd_rxrdy", i), rdy0, 1'b0);
            chkb($sformatf("v%0d_rd_perr", i), pe0, 1'b0);
        end

        bit8 = 1'b1;
        parity_en = 1'b0;
        odd_n_even = 1'b0;

        sb.push_back(8'h12);
        frame(8'h12, 1'b0);
        sb.push_back(8'h34);
        frame(8'h34, 1'b0);
        repeat (128) @(negedge clk);
        chk("ovr_dout", dout0, 8'h34);
        chkb("ovr_ovf", ov0, 1'b1);
        chkb("ovr_rxrdy", rdy0, 1'b1);
        rd();
        chkb("ovr_rd_ovf", ov0, 1'b0);

        sb.push_back(8'h12);
        frame(8'h12, 1'b0);
        sb.push_back(8'h34);
        align();
        fork
            send(8'h34, 1'b0);
            begin
                repeat (lat - 1) @(negedge clk);
                rd();
            end
        join
        repeat (128) @(negedge clk);
        chk("race_dout", dout0, 8'h34);
        chkb("race_ovf", ov0, 1'b0);
        chkb("race_rxrdy", rdy0, 1'b1);
        rd();

        align();
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        chkb("false_start_rxrdy", rdy0, 1'b0);

        sb.push_back(8'h00);
        align();
        rx = 1'b0;
        repeat (1280) @(negedge clk);
        rx = 1'b1;
        repeat (128) @(negedge clk);
        chk("brk_dout", dout0, 8'h00);
        chkb("brk_ferr", fe0, 1'b1);
        chkb("brk_ferr_fifo", fe1, 1'b1);
        chkb("brk_rxrdy", rdy0, 1'b1);
        chkb("brk_ovf", ov0, 1'b0);
        rd();
        chkb("brk_rd_ferr", fe0, 1'b0);
        sb.push_back(8'h7E);
        frame(8'h7E, 1'b0);
        repeat (128) @(negedge clk);
        chk("post_brk_dout", dout0, 8'h7E);
        chkb("post_brk_ferr", fe0, 1'b0);
        chkb("post_brk_rxrdy", rdy0, 1'b1);
        rd();

        fifo_full = 1'b1;
        frame(8'h5A, 1'b0);
        repeat (128) @(negedge clk);
        chkb("full_ovf", ov1, 1'b1);
        rd();
        chkb("full_rd_ovf", ov1, 1'b0);
        fifo_full = 1'b0;
        sb.push_back(8'h5A);
        frame(8'h5A, 1'b0);
        repeat (128) @(negedge clk);
        chkb("notfull_ovf", ov1, 1'b0);
        rd();
        chkb("fifo_rxrdy_empty", rdy1, 1'b0);
        fifo_empty = 1'b0;
        #1;
        chkb("fifo_rxrdy_nonempty", rdy1, 1'b1);
        fifo_empty = 1'b1;

        sb.push_back(8'hC3);
        frame(8'hC3, 1'b0);
        repeat (64) @(negedge clk);
        chkb("pre_rst_rxrdy", rdy0, 1'b1);
        align();
        rx = 1'b0;
        repeat (256) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_dout", dout0, 8'h00);
        chkb("midrst_rxrdy", rdy0, 1'b0);
        chkb("midrst_wr1", wr1, 1'b1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (1000) @(negedge clk);
        chkb("midrst_no_byte", rdy0, 1'b0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
